// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target memory block.
//   state_t     : protocol FSM states
//   byte_t      : one bus byte
//   I2C_*       : bus-level bit meanings (R/W flag, acknowledge levels)
package i2c_target_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_t;

  localparam logic I2C_RW_READ = 1'b1;
  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into the clk domain and produces one-clk event pulses.
//   i_clk, i_rst_n : system clock, async active-low reset
//   i_scl, i_sda   : raw bus lines (asynchronous)
//   o_sda          : synchronised SDA, aligned with the event pulses
//   o_scl_rise/o_scl_fall : synchronised SCL edges
//   o_start/o_stop : SDA fall / rise while SCL high
module i2c_bus_sync #(
  parameter int unsigned SYNC_STG = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STG-1:0] r_scl_sync;
  logic [SYNC_STG-1:0] r_sda_sync;
  logic                r_scl_d;
  logic                r_sda_d;
  logic                r_scl_rise;
  logic                r_scl_fall;
  logic                r_start;
  logic                r_stop;
  logic                w_scl;
  logic                w_sda;

  assign w_scl = r_scl_sync[SYNC_STG-1];
  assign w_sda = r_sda_sync[SYNC_STG-1];

  // Reset to the idle-high bus level so release never looks like an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STG-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STG-2:0], i_sda};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
      r_scl_rise <= w_scl & ~r_scl_d;
      r_scl_fall <= ~w_scl & r_scl_d;
      r_start    <= r_scl_d & w_scl & r_sda_d & ~w_sda;
      r_stop     <= r_scl_d & w_scl & ~r_sda_d & w_sda;
    end
  end

  // r_sda_d is the SDA level the pulses were computed from, one clk later.
  assign o_sda      = r_sda_d;
  assign o_scl_rise = r_scl_rise;
  assign o_scl_fall = r_scl_fall;
  assign o_start    = r_start;
  assign o_stop     = r_stop;

endmodule

// File: rtl/i2c_target_mem.sv
// I2C target with a byte-addressed register memory (EEPROM-style access).
//   clk_i, rst_n_i : system clock (>= 8x SCL), async active-low reset
//   scl_i, sda_i   : bus lines, asynchronous to clk_i
//   sda_o          : open-drain drive value, constant low
//   sda_dir_o      : 1 pulls SDA low, 0 releases
//   busy_o         : addressed and transfer in progress
//   wr_evt_o       : one-clk pulse per byte committed to memory
module i2c_target_mem
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  TGT_ADDR  = 7'h50,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned SYNC_STG  = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic sda_dir_o,
  output logic busy_o,
  output logic wr_evt_o
);

  localparam int unsigned PTR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CNT_W = 4;

  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  state_t             r_state;
  logic [CNT_W-1:0]   r_bit_cnt;
  byte_t              r_shift;
  logic [PTR_W-1:0]   r_ptr;
  logic               r_rw;
  logic               r_sda_dir;
  logic               r_busy;
  logic               r_wr_evt;
  byte_t              r_mem [MEM_DEPTH];

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  byte_t              w_shift_nxt;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic               w_rw_nxt;
  logic               w_dir_nxt;
  logic               w_busy_nxt;
  logic               w_wr_evt_nxt;
  logic               w_mem_we;
  byte_t              w_byte;
  byte_t              w_rd_byte;

  i2c_bus_sync #(.SYNC_STG(SYNC_STG)) u_sync (
    .i_clk      (clk_i),
    .i_rst_n    (rst_n_i),
    .i_scl      (scl_i),
    .i_sda      (sda_i),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  // Pointer advance with wrap at the last memory location.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (32'(p) >= MEM_DEPTH - 1) return '0;
    return p + PTR_W'(1);
  endfunction

  assign w_byte    = {r_shift[6:0], w_sda};
  assign w_rd_byte = r_mem[r_ptr];

  // Next-state and register updates. Bus conditions win over bit sampling.
  // In the ACK states r_bit_cnt==8 means the ACK clock has not risen yet,
  // 0 means it has, so the following fall ends the ACK slot.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_bit_cnt;
    w_shift_nxt  = r_shift;
    w_ptr_nxt    = r_ptr;
    w_rw_nxt     = r_rw;
    w_dir_nxt    = r_sda_dir;
    w_busy_nxt   = r_busy;
    w_wr_evt_nxt = 1'b0;
    w_mem_we     = 1'b0;

    if (w_start) begin
      w_state_nxt = ADDR;
      w_cnt_nxt   = '0;
      w_dir_nxt   = 1'b0;
      w_busy_nxt  = 1'b0;
    end else if (w_stop) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_dir_nxt   = 1'b0;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
        end

        ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = CNT_W'(r_bit_cnt + CNT_W'(1));
            if (r_bit_cnt == CNT_W'(7)) begin
              // General call (all-zero address) is never claimed.
              if (r_shift[6:0] == TGT_ADDR && r_shift[6:0] != 7'h00) begin
                w_state_nxt = ADDR_ACK;
                w_rw_nxt    = w_sda;
                w_busy_nxt  = 1'b1;
                w_cnt_nxt   = CNT_W'(8);
              end else begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
              end
            end
          end
        end

        ADDR_ACK, PTR_ACK, WR_ACK: begin
          if (w_scl_rise) begin
            w_cnt_nxt = '0;
          end else if (w_scl_fall) begin
            if (r_bit_cnt == CNT_W'(8)) begin
              w_dir_nxt = 1'b1;
            end else begin
              w_dir_nxt = 1'b0;
              w_cnt_nxt = '0;
              if (r_state == ADDR_ACK && r_rw == I2C_RW_READ) begin
                // First read bit goes out in this same SCL low phase.
                w_state_nxt = RD_DATA;
                w_dir_nxt   = ~w_rd_byte[7];
                w_shift_nxt = {w_rd_byte[6:0], 1'b0};
              end else if (r_state == ADDR_ACK) begin
                w_state_nxt = PTR;
              end else begin
                w_state_nxt = WR_DATA;
              end
            end
          end
        end

        PTR: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = CNT_W'(r_bit_cnt + CNT_W'(1));
            if (r_bit_cnt == CNT_W'(7)) begin
              w_ptr_nxt   = PTR_W'(w_byte);
              w_state_nxt = PTR_ACK;
            end
          end
        end

        WR_DATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = CNT_W'(r_bit_cnt + CNT_W'(1));
            if (r_bit_cnt == CNT_W'(7)) begin
              w_mem_we     = 1'b1;
              w_wr_evt_nxt = 1'b1;
              w_ptr_nxt    = ptr_inc(r_ptr);
              w_state_nxt  = WR_ACK;
            end
          end
        end

        RD_DATA: begin
          if (w_scl_rise) begin
            w_cnt_nxt = CNT_W'(r_bit_cnt + CNT_W'(1));
          end else if (w_scl_fall) begin
            if (r_bit_cnt == CNT_W'(8)) begin
              w_dir_nxt   = 1'b0;
              w_state_nxt = RD_ACK;
            end else begin
              w_dir_nxt   = ~r_shift[7];
              w_shift_nxt = {r_shift[6:0], 1'b0};
            end
          end
        end

        RD_ACK: begin
          if (w_scl_rise) begin
            w_cnt_nxt = '0;
            w_ptr_nxt = ptr_inc(r_ptr);
            if (w_sda == I2C_NACK) begin
              w_state_nxt = WAIT_STOP;
              w_busy_nxt  = 1'b0;
            end
          end else if (w_scl_fall && r_bit_cnt == '0) begin
            w_state_nxt = RD_DATA;
            w_dir_nxt   = ~w_rd_byte[7];
            w_shift_nxt = {w_rd_byte[6:0], 1'b0};
          end
        end

        WAIT_STOP: begin
        end

        default: begin
          w_state_nxt = IDLE;
          w_dir_nxt   = 1'b0;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_ptr     <= '0;
      r_rw      <= 1'b0;
      r_sda_dir <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_evt  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_ptr     <= w_ptr_nxt;
      r_rw      <= w_rw_nxt;
      r_sda_dir <= w_dir_nxt;
      r_busy    <= w_busy_nxt;
      r_wr_evt  <= w_wr_evt_nxt;
    end
  end

  // Memory array; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (w_mem_we) r_mem[r_ptr] <= w_byte;
  end

  assign sda_o     = I2C_ACK;
  assign sda_dir_o = r_sda_dir;
  assign busy_o    = r_busy;
  assign wr_evt_o  = r_wr_evt;

endmodule
